lynx_mem_map: RTL and testbench

Parametrised memory-map and paging unit for the Lynx family (48K/96K/96K-Scorpio/128K). It decodes CPU cycles into ROM/RAM/video-plane selects and holds the bank registers (port 7F bank select, port 80 video control). Unlike the fixed glue logic it replaces, it supports N video planes and a configurable RAM size. It arbitrates CPU video-RAM accesses against CRTC display fetch with a wait-state FSM, and emits single-shot write strobes. It sits between the Z80 core and the ROM/RAM/dual-port video RAM instances in the machine top.

---
 rtl/lynx_pkg.sv | 40 ++++
 rtl/lynx_vwait_fsm.sv | 67 ++++++
 rtl/lynx_mem_map.sv | 151 +++++++++++++++
 tb/tb_lynx_mem_map.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lynx_pkg.sv
// Lynx memory map: shared types, port constants and reset values.
// Imported by lynx_mem_map and lynx_vwait_fsm.
package lynx_pkg;

  typedef enum logic [1:0] {
    MODE_48K  = 2'd0,
    MODE_96K  = 2'd1,
    MODE_96KS = 2'd2,
    MODE_128K = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_WAIT = 2'd1,
    V_ACC  = 2'd2,
    V_HOLD = 2'd3
  } vstate_e;

  // Bank select decodes on a[6:0] only.
  localparam logic [6:0] P_BANK = 7'h7F;

  // Video control decodes a[7]=1, a[6]=0, a[2]=0, a[1]=0.
  localparam logic [7:0] P_VCTL      = 8'h80;
  localparam logic [7:0] P_VCTL_MASK = 8'hC6;

  // Video control bits [5:1] after reset (8'h0C).
  localparam logic [4:0] REG80_RST = 5'b00110;

  // ROM window from a[15:13]; 96K machines add 4000-5FFF.
  function automatic logic rom_win(
    input mode_e      m,
    input logic [2:0] ahi
  );
    logic ext;
    ext     = (m == MODE_96K) || (m == MODE_96KS);
    rom_win = (ahi[2:1] == 2'b00)
           || (ext && (ahi == 3'b010));
  endfunction

endpackage

// File: rtl/lynx_vwait_fsm.sv
// CPU video-RAM access arbiter: IDLE/WAIT/ACC/HOLD with bounded wait.
// In: clk/rst, cep, req, busy (CRTC fetch), mreq_n. Out: wait_n, acc.
module lynx_vwait_fsm
  import lynx_pkg::*;
#(
  parameter int MAXWAIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cep_i,
  input  logic req_i,
  input  logic busy_i,
  input  logic mreq_n_i,
  output logic wait_n_o,
  output logic acc_o
);

  localparam int CW = (MAXWAIT < 2) ? 1
                    : $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAXWAIT);

  vstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= V_IDLE;
      cnt_q   <= '0;
    end else if (cep_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      V_IDLE: begin
        cnt_d = '0;
        if (req_i)
          state_d = busy_i ? V_WAIT : V_ACC;
      end
      V_WAIT: begin
        // A CPU cycle abandoned mid-wait never writes.
        if (mreq_n_i)
          state_d = V_IDLE;
        else if (!busy_i || (cnt_q == CMAX))
          state_d = V_ACC;
        else
          cnt_d = cnt_q + 1'b1;
      end
      V_ACC:  state_d = V_HOLD;
      V_HOLD: begin
        if (mreq_n_i)
          state_d = V_IDLE;
      end
      default: state_d = V_IDLE;
    endcase
  end

  always_comb begin
    wait_n_o = (state_q != V_WAIT);
    acc_o    = (state_q == V_ACC);
  end

endmodule

// File: rtl/lynx_mem_map.sv
// Lynx memory map/paging: ROM/RAM/plane decode, 7F/80 regs, strobes.
// In: Z80 bus, mode, vid_busy, cas. Out: selects, addrs, strobes, reg80.
module lynx_mem_map
  import lynx_pkg::*;
#(
  parameter int NPLANES = 3,
  parameter int RAM_AW  = 16,
  parameter int VAW     = 14,
  parameter int MAXWAIT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cep,
  input  logic               cev,
  input  logic [1:0]         mode,
  input  logic               mreq_n,
  input  logic               iorq_n,
  input  logic               wr_n,
  input  logic [15:0]        a,
  input  logic [7:0]         cpu_do,
  input  logic               vid_busy,
  input  logic               cas,
  output logic               wait_n,
  output logic               rom_cs,
  output logic               ram_cs,
  output logic               ram_we,
  output logic [RAM_AW-1:0]  ram_a,
  output logic [NPLANES-1:0] vram_we,
  output logic [VAW-1:0]     vram_a,
  output logic [NPLANES-1:0] plane_rd,
  output logic [4:0]         reg80,
  output logic               cas23
);

  logic [7:0] reg7f_q, reg7f_d;
  logic [4:0] reg80_q, reg80_d;
  logic       ram_we_q, ram_we_d;
  logic       wr_seen_q, wr_seen_d;
  logic       cas_q, cas_d;
  logic       cas23_q, cas23_d;

  mode_e               md;
  logic                io_wr;
  logic                sel_7f;
  logic                sel_80;
  logic                wr_cyc;
  logic [NPLANES-1:0]  plane_en;
  logic                vreq;
  logic                vacc;
  logic [13:0]         fold_a;
  logic                unused_bits;

  assign md     = mode_e'(mode);
  assign io_wr  = !iorq_n && !wr_n;
  assign sel_7f = io_wr && (a[6:0] == P_BANK);
  assign sel_80 = io_wr
               && ((a[7:0] & P_VCTL_MASK) == P_VCTL);
  assign wr_cyc = !mreq_n && !wr_n;

  assign plane_en = reg7f_q[NPLANES:1];
  assign vreq     = !mreq_n && reg80_q[4] && (|plane_en);

  assign fold_a = {a[14], a[12:0]};
  assign ram_a  = (md == MODE_48K) ? RAM_AW'(fold_a)
                                   : a[RAM_AW-1:0];
  assign vram_a = VAW'(fold_a);

  always_comb begin
    rom_cs = !mreq_n && !reg7f_q[4]
          && rom_win(md, a[15:13]);
    ram_cs = !mreq_n && !reg7f_q[5] && !rom_cs;
  end

  // reg80_q[k] holds port-80 bit k+1, so plane i is blocked by [1+i].
  always_comb begin
    logic found;
    plane_rd = '0;
    found    = 1'b0;
    for (int i = 0; i < NPLANES; i++) begin
      if (!found && !reg80_q[1+i]) begin
        plane_rd[i] = 1'b1;
        found       = 1'b1;
      end
    end
    if (mreq_n || !reg7f_q[6])
      plane_rd = '0;
  end

  always_comb begin
    reg7f_d   = reg7f_q;
    reg80_d   = reg80_q;
    ram_we_d  = ram_we_q;
    wr_seen_d = wr_seen_q;
    cas_d     = cas_q;
    cas23_d   = cas23_q;
    if (cep) begin
      if (sel_7f)
        reg7f_d = cpu_do;
      if (sel_80)
        reg80_d = cpu_do[5:1];
      // Writes claimed by the video path stay out of main RAM.
      ram_we_d  = wr_cyc && !wr_seen_q
               && !reg7f_q[0] && !vreq;
      wr_seen_d = wr_cyc;
    end
    if (cev) begin
      cas_d = cas;
      if (cas_q && !cas)
        cas23_d = !cas23_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg7f_q   <= 8'h00;
      reg80_q   <= REG80_RST;
      ram_we_q  <= 1'b0;
      wr_seen_q <= 1'b0;
      cas_q     <= 1'b0;
      cas23_q   <= 1'b0;
    end else begin
      reg7f_q   <= reg7f_d;
      reg80_q   <= reg80_d;
      ram_we_q  <= ram_we_d;
      wr_seen_q <= wr_seen_d;
      cas_q     <= cas_d;
      cas23_q   <= cas23_d;
    end
  end

  lynx_vwait_fsm #(
    .MAXWAIT (MAXWAIT)
  ) u_vwait (
    .clk_i    (clock),
    .rst_i    (reset),
    .cep_i    (cep),
    .req_i    (vreq),
    .busy_i   (vid_busy),
    .mreq_n_i (mreq_n),
    .wait_n_o (wait_n),
    .acc_o    (vacc)
  );

  assign vram_we = (vacc && wr_cyc) ? plane_en : '0;
  assign ram_we  = ram_we_q;
  assign reg80   = reg80_q;
  assign cas23   = cas23_q;

  assign unused_bits = reg7f_q[7];

endmodule

// File: tb/tb_lynx_mem_map.sv
// Directed bench for lynx_mem_map: decode, paging regs, strobes,
// video wait arbitration and cassette blink phase.
module tb_lynx_mem_map;

  logic        clock = 1'b0;
  logic        reset;
  logic        cep;
  logic        cev;
  logic [1:0]  mode;
  logic        mreq_n;
  logic        iorq_n;
  logic        wr_n;
  logic [15:0] a;
  logic [7:0]  cpu_do;
  logic        vid_busy;
  logic        cas;
  logic        wait_n;
  logic        rom_cs;
  logic        ram_cs;
  logic        ram_we;
  logic [15:0] ram_a;
  logic [2:0]  vram_we;
  logic [13:0] vram_a;
  logic [2:0]  plane_rd;
  logic [4:0]  reg80;
  logic        cas23;

  int n_cmp = 0;
  int n_bad = 0;

  int         wl, wi, wc, rwc, cnt, tg;
  logic [2:0] wv;
  logic       prev;

  lynx_mem_map #(
    .NPLANES (3),
    .RAM_AW  (16),
    .VAW     (14),
    .MAXWAIT (15)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cep      (cep),
    .cev      (cev),
    .mode     (mode),
    .mreq_n   (mreq_n),
    .iorq_n   (iorq_n),
    .wr_n     (wr_n),
    .a        (a),
    .cpu_do   (cpu_do),
    .vid_busy (vid_busy),
    .cas      (cas),
    .wait_n   (wait_n),
    .rom_cs   (rom_cs),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_a    (ram_a),
    .vram_we  (vram_we),
    .vram_a   (vram_a),
    .plane_rd (plane_rd),
    .reg80    (reg80),
    .cas23    (cas23)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic io_out(input logic [7:0] port,
                        input logic [7:0] d);
    a      = {8'h00, port};
    cpu_do = d;
    iorq_n = 1'b0;
    wr_n   = 1'b0;
    tick(1);
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    a      = 16'h0000;
  endtask

  task automatic mem_wr(input logic [15:0] ad,
                        input logic [7:0]  d);
    a      = ad;
    cpu_do = d;
    mreq_n = 1'b0;
    wr_n   = 1'b0;
  endtask

  task automatic bus_rel();
    mreq_n = 1'b1;
    wr_n   = 1'b1;
  endtask

  // Runs n ceps; drops vid_busy after sample number drop.
  task automatic vid_run(input  int         n,
                         input  int         drop,
                         output int         o_wl,
                         output int         o_wi,
                         output int         o_wc,
                         output logic [2:0] o_wv,
                         output int         o_rw);
    o_wl = 0; o_wi = 0; o_wc = 0;
    o_wv = '0; o_rw = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (!wait_n) o_wl++;
      if (ram_we)  o_rw++;
      if (vram_we != 3'b000) begin
        o_wc++;
        if (o_wi == 0) o_wi = i;
        o_wv = vram_we;
      end
      if (i == drop) vid_busy = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    cep      = 1'b1;
    cev      = 1'b1;
    mode     = 2'd0;
    mreq_n   = 1'b1;
    iorq_n   = 1'b1;
    wr_n     = 1'b1;
    a        = 16'h0000;
    cpu_do   = 8'h00;
    vid_busy = 1'b0;
    cas      = 1'b0;
    tick(2);
    chk("rst_wait_n",  wait_n,  1);
    chk("rst_reg80",   reg80,   5'b00110);
    chk("rst_cas23",   cas23,   0);
    chk("rst_ram_we",  ram_we,  0);
    chk("rst_vram_we", vram_we, 0);
    reset = 1'b0;
    tick(1);

    // Plane read select against reset reg80 (bits 2,3 set)
    io_out(8'h7F, 8'h40);
    mreq_n = 1'b0; a = 16'h4000; #1;
    chk("plane_rd_rst80", plane_rd, 3'b100);
    chk("ram_cs_4000",    ram_cs,   1);
    mreq_n = 1'b1;
    io_out(8'h80, 8'h04);
    chk("reg80_04", reg80, 5'b00010);
    mreq_n = 1'b0; a = 16'h4000; #1;
    chk("plane_rd_80_04", plane_rd, 3'b010);
    mreq_n = 1'b1;
    cep = 1'b0;
    io_out(8'h7F, 8'h00);
    cep = 1'b1;
    io_out(8'hFE, 8'hFF);
    mreq_n = 1'b0; a = 16'h4000; #1;
    chk("plane_rd_nocep", plane_rd, 3'b010);
    chk("reg80_other_io", reg80,    5'b00010);
    mreq_n = 1'b1;

    // ROM / RAM read decode
    io_out(8'h7F, 8'h00);
    mode = 2'd0; mreq_n = 1'b0; a = 16'h3000; #1;
    chk("rom_48k_3000", rom_cs, 1);
    chk("ram_48k_3000", ram_cs, 0);
    a = 16'h5000; #1;
    chk("rom_48k_5000", rom_cs, 0);
    chk("ram_48k_5000", ram_cs, 1);
    mode = 2'd1; #1;
    chk("rom_96k_5000", rom_cs, 1);
    mode = 2'd3; #1;
    chk("rom_128k_5000", rom_cs, 0);
    mreq_n = 1'b1;
    io_out(8'h7F, 8'h10);
    mode = 2'd0; mreq_n = 1'b0; a = 16'h0000; #1;
    chk("rom_dis", rom_cs, 0);
    chk("ram_rom_dis", ram_cs, 1);
    mreq_n = 1'b1;
    io_out(8'h7F, 8'h30);
    mreq_n = 1'b0; #1;
    chk("ram_dis", ram_cs, 0);
    mreq_n = 1'b1;

    // RAM write folding and single-shot strobe
    io_out(8'h7F, 8'h00);
    mode = 2'd0;
    mem_wr(16'hC123, 8'hA5); #1;
    chk("ram_a_48k", ram_a, 16'h2123);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (ram_we) cnt++;
    end
    bus_rel();
    tick(1);
    if (ram_we) cnt++;
    chk("ram_we_width", cnt, 1);
    mode = 2'd3; a = 16'hC123; #1;
    chk("ram_a_128k", ram_a, 16'hC123);
    io_out(8'h7F, 8'h01);
    mem_wr(16'hC123, 8'hA5);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (ram_we) cnt++;
    end
    bus_rel();
    tick(1);
    chk("ram_we_wprot", cnt, 0);

    // Uncontended video write to planes 0 and 1
    io_out(8'h80, 8'h20);
    chk("reg80_20", reg80, 5'b10000);
    io_out(8'h7F, 8'h06);
    vid_busy = 1'b0;
    mem_wr(16'h4000, 8'h5A); #1;
    chk("vram_a_4000", vram_a, 14'h2000);
    vid_run(8, 0, wl, wi, wc, wv, rwc);
    chk("unc_we_cnt", wc,  1);
    chk("unc_we_at",  wi,  1);
    chk("unc_we_val", wv,  3'b011);
    chk("unc_wait",   wl,  0);
    chk("unc_ram_we", rwc, 0);
    bus_rel();
    tick(2);

    // Contended: vid_busy held for 5 ceps
    vid_busy = 1'b1;
    mem_wr(16'h4000, 8'h5A);
    vid_run(12, 5, wl, wi, wc, wv, rwc);
    chk("con_wait", wl, 5);
    chk("con_we_at", wi, 6);
    chk("con_we_cnt", wc, 1);
    chk("con_we_val", wv, 3'b011);
    bus_rel();
    tick(2);

    // vid_busy stuck: forced after MAXWAIT+1 ceps
    vid_busy = 1'b1;
    mem_wr(16'h4000, 8'h5A);
    vid_run(24, 0, wl, wi, wc, wv, rwc);
    chk("frc_wait", wl, 16);
    chk("frc_we_at", wi, 17);
    chk("frc_we_cnt", wc, 1);
    bus_rel();
    vid_busy = 1'b0;
    tick(2);

    // Aborted cycle while waiting
    vid_busy = 1'b1;
    mem_wr(16'h4000, 8'h5A);
    tick(3);
    chk("abt_in_wait", wait_n, 0);
    bus_rel();
    vid_run(5, 0, wl, wi, wc, wv, rwc);
    chk("abt_wait", wl, 0);
    chk("abt_we_cnt", wc, 0);
    vid_busy = 1'b0;
    tick(1);

    // Cassette blink phase
    cas = 1'b0;
    tick(1);
    prev = cas23;
    tg = 0;
    repeat (4) begin
      cas = 1'b1; tick(1);
      if (cas23 != prev) tg++;
      prev = cas23;
      cas = 1'b0; tick(1);
      if (cas23 != prev) tg++;
      prev = cas23;
    end
    chk("cas_toggles", tg, 4);
    chk("cas23_even", cas23, 0);
    cev = 1'b0;
    cas = 1'b1; tick(1);
    cas = 1'b0; tick(1);
    cev = 1'b1; tick(1);
    chk("cas_cev_gate", cas23, 0);
    cas = 1'b1; tick(1);
    cas = 1'b0; tick(1);
    chk("cas23_odd", cas23, 1);

    // Reset while waiting
    vid_busy = 1'b1;
    mem_wr(16'h4000, 8'h5A);
    tick(2);
    chk("rstw_in_wait", wait_n, 0);
    reset = 1'b1; #1;
    chk("rstw_wait_n", wait_n,  1);
    chk("rstw_vram",   vram_we, 0);
    chk("rstw_cas23",  cas23,   0);
    bus_rel();
    vid_busy = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rstw_reg80",  reg80,   5'b00110);
    chk("rstw_wait2",  wait_n,  1);
    chk("rstw_vram2",  vram_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
